// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single system bus port.
// Serves the core and the debug module one transaction at a time, with decode and timeout faults.
module bus_arbiter #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int Timeout      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c_req,
    input  logic                    c_we,
    input  logic [DataWidth/8-1:0]  c_be,
    input  logic [AddressWidth-1:0] c_addr,
    input  logic [DataWidth-1:0]    c_wdata,
    output logic                    c_gnt,
    output logic                    c_done,
    output logic                    c_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DataWidth/8-1:0]  d_be,
    input  logic [AddressWidth-1:0] d_addr,
    input  logic [DataWidth-1:0]    d_wdata,
    output logic                    d_gnt,
    output logic                    d_done,
    output logic                    d_err,
    output logic [DataWidth-1:0]    rdata,
    output logic                    m_req,
    output logic                    m_we,
    output logic [DataWidth/8-1:0]  m_be,
    output logic [AddressWidth-1:0] m_addr,
    output logic [DataWidth-1:0]    m_wdata,
    input  logic                    m_hit,
    input  logic                    m_ready,
    input  logic [DataWidth-1:0]    m_rdata
);

    localparam int BeWidth    = DataWidth / 8;
    localparam int CountWidth = $clog2(Timeout + 1);
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(Timeout - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CountWidth-1:0]   count;
    logic                    owner_debug;
    logic                    last_debug;
    logic                    err_flag;
    logic [DataWidth-1:0]    rdata_q;
    logic                    cap_we;
    logic [BeWidth-1:0]      cap_be;
    logic [AddressWidth-1:0] cap_addr;
    logic [DataWidth-1:0]    cap_wdata;

    logic grant;
    logic pick_debug;
    logic finish;
    logic fault;

    // The first BUSY cycle is the only one with a zero count, so it doubles as the decode check point.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        pick_debug = 1'b0;
        finish     = 1'b0;
        fault      = 1'b0;
        c_gnt      = 1'b0;
        d_gnt      = 1'b0;
        c_done     = 1'b0;
        d_done     = 1'b0;
        c_err      = 1'b0;
        d_err      = 1'b0;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_be       = '0;
        m_addr     = '0;
        m_wdata    = '0;
        unique case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    grant      = 1'b1;
                    pick_debug = d_req && (!c_req || !last_debug);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                m_req   = 1'b1;
                m_we    = cap_we;
                m_be    = cap_be;
                m_addr  = cap_addr;
                m_wdata = cap_wdata;
                if (count == '0 && !m_hit) begin
                    fault      = 1'b1;
                    state_next = RESP;
                end else if (m_ready) begin
                    finish     = 1'b1;
                    state_next = RESP;
                end else if (count == CountLast) begin
                    fault      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                c_done     = !owner_debug && !rst;
                d_done     = owner_debug && !rst;
                c_err      = !owner_debug && !rst && err_flag;
                d_err      = owner_debug && !rst && err_flag;
            end
            default: state_next = IDLE;
        endcase
        c_gnt = grant && !pick_debug && !rst;
        d_gnt = grant && pick_debug && !rst;
    end

    assign rdata = rdata_q;

    // Capture the winner at the grant edge; rdata only changes on entry to RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            owner_debug <= 1'b0;
            last_debug  <= 1'b1;
            err_flag    <= 1'b0;
            rdata_q     <= '0;
            cap_we      <= 1'b0;
            cap_be      <= '0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner_debug <= pick_debug;
                last_debug  <= pick_debug;
                count       <= '0;
                err_flag    <= 1'b0;
                cap_we      <= pick_debug ? d_we    : c_we;
                cap_be      <= pick_debug ? d_be    : c_be;
                cap_addr    <= pick_debug ? d_addr  : c_addr;
                cap_wdata   <= pick_debug ? d_wdata : c_wdata;
            end
            if (state == BUSY && !m_ready) begin
                count <= count + CountWidth'(1);
            end
            if (fault) begin
                err_flag <= 1'b1;
                rdata_q  <= '0;
            end else if (finish) begin
                err_flag <= 1'b0;
                rdata_q  <= cap_we ? '0 : m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level round-robin / outcome model.
module tb_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [3:0]  c_be, d_be;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_done, c_err, d_gnt, d_done, d_err;
    logic [31:0] rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_hit, m_ready;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    // model state: which requester was granted last, and the rdata the bus should be holding
    logic        last_dbg;
    logic [31:0] exp_rdata;

    // observations of one transaction, filled by drive_txn
    logic        ob_cg, ob_dg, ob_cd, ob_dd, ob_err, ob_multi, ob_stable, ob_hung;
    logic        ob_we;
    logic [3:0]  ob_be;
    logic [31:0] ob_addr, ob_wdata, ob_rdata;
    int          ob_busy, ob_done_cyc;

    bus_arbiter #(.DataWidth(32), .AddressWidth(32), .Timeout(TO)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err),
        .rdata(rdata), .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_hit(m_hit), .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Runs one transaction from the IDLE cycle to the done pulse; only records what it sees.
    task automatic drive_txn(input logic creq, input logic dreq,
                             input logic cwe, input logic [3:0] cbe, input logic [31:0] caddr, input logic [31:0] cwdata,
                             input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr, input logic [31:0] dwdata,
                             input logic hit, input int ready_at, input logic [31:0] rd_val);
        @(negedge clk);
        c_req = creq; c_we = cwe; c_be = cbe; c_addr = caddr; c_wdata = cwdata;
        d_req = dreq; d_we = dwe; d_be = dbe; d_addr = daddr; d_wdata = dwdata;
        m_hit = 1'b0; m_ready = 1'b0;
        #1;
        ob_cg = c_gnt; ob_dg = d_gnt; ob_multi = c_gnt && d_gnt;
        ob_busy = 0; ob_done_cyc = 0; ob_stable = 1'b1; ob_hung = 1'b1;
        ob_cd = 1'b0; ob_dd = 1'b0; ob_err = 1'b0; ob_rdata = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            m_hit = hit; m_ready = (n == ready_at);
            m_rdata = (n == ready_at) ? rd_val : $urandom;
            c_req = 1'($urandom); d_req = 1'($urandom);
            c_we = 1'($urandom); d_we = 1'($urandom); c_be = 4'($urandom); d_be = 4'($urandom);
            c_addr = $urandom; d_addr = $urandom; c_wdata = $urandom; d_wdata = $urandom;
            #1;
            if (c_gnt || d_gnt || (c_done && d_done) || (m_req && (c_done || d_done))) ob_multi = 1'b1;
            if (m_req) begin
                ob_busy++;
                if (ob_busy == 1) begin
                    ob_we = m_we; ob_be = m_be; ob_addr = m_addr; ob_wdata = m_wdata;
                end else if (m_we !== ob_we || m_be !== ob_be || m_addr !== ob_addr || m_wdata !== ob_wdata) begin
                    ob_stable = 1'b0;
                end
            end
            if (c_done || d_done) begin
                ob_cd = c_done; ob_dd = d_done; ob_err = c_err | d_err;
                ob_rdata = rdata; ob_done_cyc = n; ob_hung = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c_req = 1'($urandom); d_req = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; c_req = 1'b0; d_req = 1'b0;
        #1;
        last_dbg = 1'b1; exp_rdata = '0;
        checks++;
        if ({c_gnt, d_gnt, c_done, d_done, c_err, d_err, m_req, m_we} !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 00000000", {c_gnt, d_gnt, c_done, d_done, c_err, d_err, m_req, m_we});
        end
        checks++;
        if ({m_be, m_addr, m_wdata} !== '0) begin
            errors++; $display("[TB] FAIL reset_fields: got be=%h addr=%h wdata=%h expected 0", m_be, m_addr, m_wdata);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
        end
    endtask

    task automatic test_round_robin();
        logic exp_dbg;
        logic [31:0] rv;
        for (int i = 0; i < 4; i++) begin
            rv = $urandom;
            drive_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h100 + 32'(i), 32'h0, 1'b0, 4'h3, 32'h200 + 32'(i), 32'h0, 1'b1, 1, rv);
            exp_dbg = !last_dbg;
            last_dbg = exp_dbg;
            exp_rdata = rv;
            checks++;
            if ({ob_cg, ob_dg} !== {!exp_dbg, exp_dbg} || exp_dbg !== 1'(i % 2)) begin
                errors++; $display("[TB] FAIL rr_grant_%0d: got c=%b d=%b expected %s", i, ob_cg, ob_dg, (i % 2) ? "debug" : "core");
            end
            checks++;
            if (ob_multi !== 1'b0 || ob_hung !== 1'b0) begin
                errors++; $display("[TB] FAIL rr_single_%0d: got multi=%b hung=%b expected 0 0", i, ob_multi, ob_hung);
            end
            checks++;
            if (ob_addr !== (exp_dbg ? 32'h200 + 32'(i) : 32'h100 + 32'(i)) || ob_rdata !== rv) begin
                errors++; $display("[TB] FAIL rr_data_%0d: got addr=%h rdata=%h expected rdata %h", i, ob_addr, ob_rdata, rv);
            end
        end
    endtask

    task automatic test_basic_read();
        drive_txn(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 32'hDEAD_BEEF);
        last_dbg = 1'b0; exp_rdata = 32'hDEAD_BEEF;
        checks++;
        if ({ob_cg, ob_dg} !== 2'b10) begin
            errors++; $display("[TB] FAIL basic_gnt: got c=%b d=%b expected c=1 d=0", ob_cg, ob_dg);
        end
        checks++;
        if (ob_done_cyc !== 2 || ob_cd !== 1'b1 || ob_dd !== 1'b0 || ob_err !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_done: got cycle=%0d cd=%b dd=%b err=%b expected 2 1 0 0", ob_done_cyc, ob_cd, ob_dd, ob_err);
        end
        checks++;
        if (ob_rdata !== 32'hDEAD_BEEF || ob_addr !== 32'h10 || ob_we !== 1'b0 || ob_be !== 4'hF) begin
            errors++; $display("[TB] FAIL basic_data: got rdata=%h addr=%h we=%b be=%h expected deadbeef 10 0 f", ob_rdata, ob_addr, ob_we, ob_be);
        end
    endtask

    task automatic test_decode_fault();
        drive_txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hC, 32'h8000_0000, 32'hCAFE_F00D, 1'b0, 1, 32'h1111_2222);
        last_dbg = 1'b1; exp_rdata = '0;
        checks++;
        if (ob_dg !== 1'b1 || ob_busy !== 1 || ob_dd !== 1'b1 || ob_err !== 1'b1) begin
            errors++; $display("[TB] FAIL decode_fault: got gnt=%b busy=%0d done=%b err=%b expected 1 1 1 1", ob_dg, ob_busy, ob_dd, ob_err);
        end
        checks++;
        if (ob_rdata !== 32'h0 || ob_we !== 1'b1 || ob_wdata !== 32'hCAFE_F00D) begin
            errors++; $display("[TB] FAIL decode_data: got rdata=%h we=%b wdata=%h expected 0 1 cafef00d", ob_rdata, ob_we, ob_wdata);
        end
    endtask

    task automatic test_timeout();
        drive_txn(1'b1, 1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 32'h0);
        last_dbg = 1'b0; exp_rdata = '0;
        checks++;
        if (ob_busy !== TO || ob_cd !== 1'b1 || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL timeout_err: got busy=%0d done=%b err=%b rdata=%h expected %0d 1 1 0", ob_busy, ob_cd, ob_err, ob_rdata, TO);
        end
        drive_txn(1'b1, 1'b0, 1'b0, 4'hF, 32'h44, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, TO, 32'h1234_5678);
        exp_rdata = 32'h1234_5678;
        checks++;
        if (ob_busy !== TO || ob_cd !== 1'b1 || ob_err !== 1'b0 || ob_rdata !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL timeout_ready: got busy=%0d done=%b err=%b rdata=%h expected %0d 1 0 12345678", ob_busy, ob_cd, ob_err, ob_rdata, TO);
        end
    endtask

    task automatic test_random();
        logic cr, dr, cwe, dwe, hit, exp_dbg, exp_err, exp_we;
        logic [3:0] cbe, dbe;
        logic [31:0] ca, da, cw, dw, rv, exp_addr;
        int ra, exp_busy;
        for (int i = 0; i < 24; i++) begin
            cr = 1'($urandom); dr = 1'($urandom);
            if (!cr && !dr) cr = 1'b1;
            cwe = 1'($urandom); dwe = 1'($urandom); cbe = 4'($urandom); dbe = 4'($urandom);
            ca = $urandom; da = $urandom; cw = $urandom; dw = $urandom; rv = $urandom;
            hit = ($urandom_range(0, 4) != 0);
            ra = $urandom_range(0, TO + 2);
            drive_txn(cr, dr, cwe, cbe, ca, cw, dwe, dbe, da, dw, hit, ra, rv);
            exp_dbg  = (cr && dr) ? !last_dbg : dr;
            last_dbg = exp_dbg;
            exp_err  = !hit || ra < 1 || ra > TO;
            exp_busy = !hit ? 1 : (exp_err ? TO : ra);
            exp_we   = exp_dbg ? dwe : cwe;
            exp_addr = exp_dbg ? da : ca;
            exp_rdata = (exp_err || exp_we) ? 32'h0 : rv;
            checks++;
            if ({ob_cg, ob_dg} !== {!exp_dbg, exp_dbg} || ob_multi !== 1'b0) begin
                errors++; $display("[TB] FAIL rand_gnt_%0d: got c=%b d=%b multi=%b expected debug=%b", i, ob_cg, ob_dg, ob_multi, exp_dbg);
            end
            checks++;
            if (ob_busy !== exp_busy || ob_done_cyc !== exp_busy + 1 || ob_hung !== 1'b0) begin
                errors++; $display("[TB] FAIL rand_len_%0d: got busy=%0d done_cycle=%0d expected %0d", i, ob_busy, ob_done_cyc, exp_busy);
            end
            checks++;
            if ({ob_cd, ob_dd} !== {!exp_dbg, exp_dbg} || ob_err !== exp_err || ob_rdata !== exp_rdata) begin
                errors++; $display("[TB] FAIL rand_resp_%0d: got done=%b%b err=%b rdata=%h expected err=%b rdata=%h", i, ob_cd, ob_dd, ob_err, ob_rdata, exp_err, exp_rdata);
            end
            checks++;
            if (ob_we !== exp_we || ob_addr !== exp_addr || ob_be !== (exp_dbg ? dbe : cbe) ||
                ob_wdata !== (exp_dbg ? dw : cw) || ob_stable !== 1'b1) begin
                errors++; $display("[TB] FAIL rand_fields_%0d: got we=%b addr=%h be=%h stable=%b expected addr=%h", i, ob_we, ob_addr, ob_be, ob_stable, exp_addr);
            end
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c_req = 1'b0; d_req = 1'b0; m_hit = 1'($urandom); m_ready = 1'($urandom); m_rdata = $urandom;
            #1;
            checks++;
            if (rdata !== exp_rdata || {c_gnt, d_gnt, c_done, d_done, m_req, m_we} !== 6'h0 || m_addr !== 32'h0) begin
                errors++; $display("[TB] FAIL idle_hold_%0d: got rdata=%h flags=%b expected rdata=%h flags=0", i, rdata, {c_gnt, d_gnt, c_done, d_done, m_req, m_we}, exp_rdata);
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        c_req = 1'b1; d_req = 1'b0; c_we = 1'b0; c_addr = 32'h80; m_hit = 1'b1; m_ready = 1'b0;
        #1;
        checks++;
        if (c_gnt !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_gnt: got %b expected 1", c_gnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (m_req !== 1'b1 || c_done !== 1'b0 || d_done !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_busy2: got m_req=%b done=%b%b expected 1 00", m_req, c_done, d_done);
        end
        @(negedge clk);
        rst = 1'b0; c_req = 1'b1; d_req = 1'b1; d_addr = 32'h90;
        #1;
        last_dbg = 1'b1;
        checks++;
        if (m_req !== 1'b0 || c_done !== 1'b0 || d_done !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL abort_after: got m_req=%b done=%b%b rdata=%h expected 0 00 0", m_req, c_done, d_done, rdata);
        end
        checks++;
        if ({c_gnt, d_gnt} !== {!(!last_dbg), !last_dbg}) begin
            errors++; $display("[TB] FAIL abort_first_gnt: got c=%b d=%b expected core", c_gnt, d_gnt);
        end
        @(negedge clk);
        m_ready = 1'b1; m_rdata = 32'hA5A5_0001;
        @(negedge clk);
        m_ready = 1'b0; c_req = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if (c_done !== 1'b1 || c_err !== 1'b0 || rdata !== 32'hA5A5_0001) begin
            errors++; $display("[TB] FAIL abort_resume: got done=%b err=%b rdata=%h expected 1 0 a5a50001", c_done, c_err, rdata);
        end
    endtask

    initial begin
        rst = 1'b1; c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
        c_be = '0; d_be = '0; c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;
        m_hit = 1'b0; m_ready = 1'b0; m_rdata = '0;
        test_reset();
        test_round_robin();
        test_basic_read();
        test_decode_fault();
        test_timeout();
        test_random();
        test_idle_hold();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
